pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register that replaces the hand-written per-stage registers (id/ex, ex/mem, mem/wb) with one generic block.
- Takes a packed payload from stage STAGE and a multicycle carry vector, and obeys the 6-bit stall vector from CTRL and the flush line.
- Adds what the per-stage registers lack: an explicit valid bit, per-stage bubble and hold performance counters, and a stall-watchdog flag for stuck stalls.
- Sits between every pair of adjacent stages. The top level packs and unpacks the payload fields.

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/sat_counter.sv | 29 ++
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall vector layout, stage actions and
// per-boundary payload widths with their NOP encodings.
package pipe_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    ACT_RST,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } stage_action_e;

  localparam int ID_EX_PAYLOAD_W  = 200;
  localparam int EX_MEM_PAYLOAD_W = 180;
  localparam int MEM_WB_PAYLOAD_W = 110;

  localparam logic       WRITE_DISABLE = 1'b0;
  localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;

  // An all-zero payload decodes as wreg=WriteDisable, aluop=EXE_NOP_OP.
  localparam logic [ID_EX_PAYLOAD_W-1:0]  ID_EX_NOP  = '0;
  localparam logic [EX_MEM_PAYLOAD_W-1:0] EX_MEM_NOP = '0;
  localparam logic [MEM_WB_PAYLOAD_W-1:0] MEM_WB_NOP = '0;

  function automatic stage_action_e decode_action(input logic rst,
                                                  input logic flush,
                                                  input logic up,
                                                  input logic dn);
    stage_action_e act;
    if (rst)                          act = ACT_RST;
    else if (flush)                   act = ACT_FLUSH;
    else if (up == STOP && dn != STOP) act = ACT_BUBBLE;
    else if (up != STOP)              act = ACT_ADVANCE;
    else                              act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count < LIMIT)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid bit, multicycle carry loopback,
// bubble/hold performance counters and a sticky stuck-stall watchdog.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W   = 200,
  parameter int                   CARRY_W     = 66,
  parameter int                   STAGE       = 3,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter int                   CNT_W       = 16,
  parameter int                   WDOG_LIMIT  = 1023
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [STALL_W-1:0]                    stall,
  input  logic                                  flush,
  input  logic                                  in_valid,
  input  logic [PAYLOAD_W-1:0]                  in_payload,
  input  logic [((CARRY_W > 0) ? CARRY_W : 1)-1:0] in_carry,
  output logic                                  out_valid,
  output logic [PAYLOAD_W-1:0]                  out_payload,
  output logic [((CARRY_W > 0) ? CARRY_W : 1)-1:0] out_carry,
  input  logic                                  cnt_clr,
  output logic [CNT_W-1:0]                      bubble_cnt,
  output logic [CNT_W-1:0]                      hold_cnt,
  output logic                                  wdog_o
);

  if (STAGE < 0 || STAGE > 4) begin : g_badStage
    $error("pipe_stage_reg: STAGE must be in 0..4");
  end
  if (WDOG_LIMIT < 1 || WDOG_LIMIT >= (2 ** CNT_W)) begin : g_badLimit
    $error("pipe_stage_reg: WDOG_LIMIT must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0] WDOG_PRE = CNT_W'(WDOG_LIMIT - 1);

  logic          w_up;
  logic          w_dn;
  logic          w_unusedStall;
  stage_action_e w_action;
  logic          w_runInc;
  logic          w_runClr;
  logic          w_wdogSet;
  logic [CNT_W-1:0] w_runLen;

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_wdog;

  assign w_up          = stall[STAGE];
  assign w_dn          = stall[STAGE+1];
  assign w_unusedStall = ^stall;

  always_comb begin
    w_action = decode_action(rst, flush, w_up, w_dn);
  end

  assign w_runInc  = (w_action == ACT_BUBBLE) || (w_action == ACT_HOLD);
  assign w_runClr  = (w_action == ACT_FLUSH) || (w_action == ACT_ADVANCE);
  // The run length is about to reach the limit on this edge (or already sits there).
  assign w_wdogSet = w_runInc && (w_runLen >= WDOG_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_payload <= NOP_PAYLOAD;
    end else begin
      case (w_action)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_valid   <= 1'b0;
          r_payload <= NOP_PAYLOAD;
        end
        ACT_ADVANCE: begin
          r_valid   <= in_valid;
          r_payload <= in_valid ? in_payload : NOP_PAYLOAD;
        end
        default: begin
          r_valid   <= r_valid;
          r_payload <= r_payload;
        end
      endcase
    end
  end

  // Carry is only live while the upstream stage is stalled and looping state back.
  if (CARRY_W > 0) begin : g_carry
    logic [CARRY_W-1:0] r_carry;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_carry <= '0;
      end else if (w_runInc) begin
        r_carry <= in_carry;
      end else begin
        r_carry <= '0;
      end
    end

    assign out_carry = r_carry;
  end else begin : g_noCarry
    logic w_unusedCarry;
    assign w_unusedCarry = ^in_carry;
    assign out_carry     = '0;
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT ({CNT_W{1'b1}})
  ) u_bubbleCnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_action == ACT_BUBBLE),
    .i_clr   (cnt_clr),
    .o_count (bubble_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT ({CNT_W{1'b1}})
  ) u_holdCnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_action == ACT_HOLD),
    .i_clr   (cnt_clr),
    .o_count (hold_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (WDOG_LIM)
  ) u_runLen (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_runInc),
    .i_clr   (w_runClr),
    .o_count (w_runLen)
  );

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_wdog <= 1'b0;
    end else if (w_wdogSet) begin
      r_wdog <= 1'b1;
    end
  end

  assign out_valid   = r_valid;
  assign out_payload = r_payload;
  assign wdog_o      = r_wdog;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg: a cycle-level reference model checked
// every cycle, plus directed scenarios pinned with literal expectations.
module tb_pipe_stage_reg;

  localparam int PW   = 72;
  localparam int CW   = 66;
  localparam int STG  = 3;
  localparam int CNTW = 4;
  localparam int WLIM = 8;
  localparam int CMAX = (1 << CNTW) - 1;
  localparam logic [PW-1:0] NOP = 72'hC0_0000_0000_0000_0003;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      stall;
  logic            flush;
  logic            inValid;
  logic [PW-1:0]   inPayload;
  logic [CW-1:0]   inCarry;
  logic            cntClr;
  logic            outValid;
  logic [PW-1:0]   outPayload;
  logic [CW-1:0]   outCarry;
  logic [CNTW-1:0] bubbleCnt;
  logic [CNTW-1:0] holdCnt;
  logic            wdogO;

  int checkCount = 0;
  int errorCount = 0;

  pipe_stage_reg #(
    .PAYLOAD_W   (PW),
    .CARRY_W     (CW),
    .STAGE       (STG),
    .NOP_PAYLOAD (NOP),
    .CNT_W       (CNTW),
    .WDOG_LIMIT  (WLIM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (inValid),
    .in_payload  (inPayload),
    .in_carry    (inCarry),
    .out_valid   (outValid),
    .out_payload (outPayload),
    .out_carry   (outCarry),
    .cnt_clr     (cntClr),
    .bubble_cnt  (bubbleCnt),
    .hold_cnt    (holdCnt),
    .wdog_o      (wdogO)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit            mKnown = 1'b0;
  bit            mValid;
  logic [PW-1:0] mPayload;
  logic [CW-1:0] mCarry;
  int            mBubble;
  int            mHold;
  int            mRun;
  bit            mWdog;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s,
                               input logic v, input logic [PW-1:0] p,
                               input logic [CW-1:0] c, input logic clr);
    @(negedge clk);
    rst = r; flush = f; stall = s; inValid = v; inPayload = p; inCarry = c; cntClr = clr;
    @(posedge clk);
    #3;
  endtask

  // Model: next outputs straight from the boundary-register rules.
  always @(posedge clk) begin : refModel
    bit up, dn, stalled;
    up = stall[STG];
    dn = stall[STG+1];
    if (rst) begin
      mKnown = 1'b1; mValid = 1'b0; mPayload = NOP; mCarry = '0;
      mBubble = 0; mHold = 0; mRun = 0; mWdog = 1'b0;
    end else begin
      stalled = !flush && up;
      if (flush || (up && !dn)) begin
        mValid = 1'b0; mPayload = NOP;
      end else if (!up) begin
        mValid = inValid; mPayload = inValid ? inPayload : NOP;
      end
      mCarry = stalled ? inCarry : '0;
      mRun   = stalled ? ((mRun + 1 > WLIM) ? WLIM : mRun + 1) : 0;
      if (cntClr) begin
        mBubble = 0; mHold = 0; mWdog = 1'b0;
      end else begin
        if (stalled && !dn) mBubble = (mBubble < CMAX) ? mBubble + 1 : CMAX;
        if (stalled && dn)  mHold   = (mHold < CMAX) ? mHold + 1 : CMAX;
        if (stalled && mRun == WLIM) mWdog = 1'b1;
      end
    end
  end

  always @(posedge clk) begin : compare
    #2;
    if (mKnown) begin
      checkOutput("valid",   outValid,   mValid);
      checkOutput("payload", outPayload, mPayload);
      checkOutput("carry",   outCarry,   mCarry);
      checkOutput("bubble",  bubbleCnt,  mBubble);
      checkOutput("hold",    holdCnt,    mHold);
      checkOutput("wdog",    wdogO,      mWdog);
    end
  end

  initial begin : stimulus
    logic [PW-1:0] pA5;
    logic [PW-1:0] pP;
    logic [CW-1:0] cBeef;
    pA5   = {9{8'hA5}};
    pP    = 72'h5A_1234_5678_9ABC_DEF0;
    cBeef = 66'h2_DEADBEEF_12345678;
    rst = 1'b1; flush = 1'b0; stall = '0; inValid = 1'b0;
    inPayload = '0; inCarry = '0; cntClr = 1'b0;

    // Reset then advance
    applyStimulus(1, 0, 6'b000000, 1, pP, cBeef, 0);
    applyStimulus(1, 0, 6'b000000, 1, pP, cBeef, 0);
    checkOutput("rst_valid",   outValid,   1'b0);
    checkOutput("rst_payload", outPayload, NOP);
    checkOutput("rst_carry",   outCarry,   '0);
    checkOutput("rst_bubble",  bubbleCnt,  0);
    checkOutput("rst_wdog",    wdogO,      1'b0);
    applyStimulus(0, 0, 6'b000000, 1, pA5, cBeef, 0);
    checkOutput("adv_valid",   outValid,   1'b1);
    checkOutput("adv_payload", outPayload, pA5);
    checkOutput("adv_carry",   outCarry,   '0);

    // EX bubble with carry
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 6'b001111, 1, pP, cBeef, 0);
      checkOutput("bub_valid",   outValid,   1'b0);
      checkOutput("bub_payload", outPayload, NOP);
      checkOutput("bub_carry",   outCarry,   cBeef);
    end
    checkOutput("bub_count", bubbleCnt, 3);

    // Hold
    applyStimulus(0, 0, 6'b000000, 1, pP, '0, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 6'b011111, 0, pA5, CW'(i * 7), 0);
      checkOutput("hold_valid",   outValid,   1'b1);
      checkOutput("hold_payload", outPayload, pP);
      checkOutput("hold_carry",   outCarry,   CW'(i * 7));
    end
    checkOutput("hold_count",   holdCnt,   5);
    checkOutput("hold_bubbles", bubbleCnt, 3);

    // Flush beats a hold
    applyStimulus(0, 1, 6'b011111, 1, pA5, cBeef, 0);
    checkOutput("flush_valid",   outValid,   1'b0);
    checkOutput("flush_payload", outPayload, NOP);
    checkOutput("flush_carry",   outCarry,   '0);
    checkOutput("flush_hold",    holdCnt,    5);

    // Watchdog
    applyStimulus(0, 0, 6'b000000, 1, pP, '0, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 6'b011111, 0, '0, '0, 0);
      if (i == 7) checkOutput("wdog_early", wdogO, 1'b0);
    end
    checkOutput("wdog_fire", wdogO,   1'b1);
    checkOutput("wdog_hold", holdCnt, 13);
    applyStimulus(0, 0, 6'b000000, 1, pA5, '0, 0);
    checkOutput("wdog_sticky", wdogO, 1'b1);
    applyStimulus(0, 0, 6'b000000, 1, pA5, '0, 1);
    checkOutput("clr_wdog",   wdogO,     1'b0);
    checkOutput("clr_bubble", bubbleCnt, 0);
    checkOutput("clr_hold",   holdCnt,   0);

    // Saturation
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 6'b001111, 1, pP, CW'(i), 0);
      if (i == 15) checkOutput("sat_reach", bubbleCnt, 15);
    end
    checkOutput("sat_stop", bubbleCnt, 15);
    checkOutput("sat_wdog", wdogO,     1'b1);
    applyStimulus(0, 0, 6'b001111, 1, pP, cBeef, 1);
    checkOutput("clrbub_count", bubbleCnt,  0);
    checkOutput("clrbub_payload", outPayload, NOP);
    checkOutput("clrbub_carry", outCarry,   cBeef);
    applyStimulus(0, 0, 6'b001111, 1, pP, cBeef, 0);
    applyStimulus(1, 0, 6'b001111, 1, pP, cBeef, 0);
    checkOutput("midrst_bubble", bubbleCnt, 0);
    checkOutput("midrst_carry",  outCarry,  '0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] s;
      s    = 6'($urandom);
      s[3] = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0), s,
                    1'($urandom), {8'($urandom), 32'($urandom), 32'($urandom)},
                    {2'($urandom), 32'($urandom), 32'($urandom)},
                    ($urandom_range(0, 19) == 0));
    end

    applyStimulus(0, 0, 6'b000000, 0, '0, '0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
